// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin Wishbone B3 arbiter.
package wb_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Pointer width; never below one bit so a single-master build stays legal.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/wb_rr_prio.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping upward.
module wb_rr_prio
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int PW          = clog2_min1(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [PW-1:0]          i_ptr,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic                   o_valid
);

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!o_valid && i_req[j] && (((int'(i_ptr) + i) % NUM_MASTERS) == j)) begin
                    o_gnt[j] = 1'b1;
                    o_valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: grant held for a whole cyc, per-transfer watchdog
// forces err on a slave that never terminates.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int aw          = 32,
    parameter int dw          = 32,
    parameter int TIMEOUT     = 256
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_ni,
    input  logic [NUM_MASTERS*aw-1:0]       wbm_adr_i,
    input  logic [NUM_MASTERS*dw-1:0]       wbm_dat_i,
    input  logic [NUM_MASTERS*(dw/8)-1:0]   wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]          wbm_we_i,
    input  logic [NUM_MASTERS-1:0]          wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]          wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]        wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]        wbm_bte_i,
    output logic [dw-1:0]                   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]          wbm_ack_o,
    output logic [NUM_MASTERS-1:0]          wbm_err_o,
    output logic [NUM_MASTERS-1:0]          wbm_rty_o,
    output logic [aw-1:0]                   wbs_adr_o,
    output logic [dw-1:0]                   wbs_dat_o,
    output logic [dw/8-1:0]                 wbs_sel_o,
    output logic                            wbs_we_o,
    output logic                            wbs_cyc_o,
    output logic                            wbs_stb_o,
    output logic [2:0]                      wbs_cti_o,
    output logic [1:0]                      wbs_bte_o,
    input  logic [dw-1:0]                   wbs_dat_i,
    input  logic                            wbs_ack_i,
    input  logic                            wbs_err_i,
    input  logic                            wbs_rty_i,
    output logic [NUM_MASTERS-1:0]          grant_o
);

    localparam int PW  = clog2_min1(NUM_MASTERS);
    localparam int SW  = dw / 8;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

    state_e                 r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [PW-1:0]          r_ptr, w_ptr_nxt;
    logic [WDW-1:0]         r_wd, w_wd_nxt;

    logic [NUM_MASTERS-1:0] w_pick_gnt;
    logic                   w_pick_valid;
    logic [aw-1:0]          w_own_adr;
    logic [dw-1:0]          w_own_dat;
    logic [SW-1:0]          w_own_sel;
    logic                   w_own_we, w_own_cyc, w_own_stb;
    logic [2:0]             w_own_cti;
    logic [1:0]             w_own_bte;
    logic [PW-1:0]          w_owner_idx, w_ptr_inc;
    logic                   w_term, w_stall, w_expire;

    wb_rr_prio #(
        .NUM_MASTERS (NUM_MASTERS),
        .PW          (PW)
    ) u_prio (
        .i_req   (wbm_cyc_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_valid (w_pick_valid)
    );

    // AND-OR mux: grant is one-hot or zero, so an idle arbiter drives all zeros.
    always_comb begin
        w_own_adr   = '0;
        w_own_dat   = '0;
        w_own_sel   = '0;
        w_own_we    = 1'b0;
        w_own_cyc   = 1'b0;
        w_own_stb   = 1'b0;
        w_own_cti   = '0;
        w_own_bte   = '0;
        w_owner_idx = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (r_grant[m]) begin
                w_own_adr   |= wbm_adr_i[m*aw +: aw];
                w_own_dat   |= wbm_dat_i[m*dw +: dw];
                w_own_sel   |= wbm_sel_i[m*SW +: SW];
                w_own_we    |= wbm_we_i[m];
                w_own_cyc   |= wbm_cyc_i[m];
                w_own_stb   |= wbm_stb_i[m];
                w_own_cti   |= wbm_cti_i[m*3 +: 3];
                w_own_bte   |= wbm_bte_i[m*2 +: 2];
                w_owner_idx  = PW'(m);
            end
        end
    end

    assign w_ptr_inc = (int'(w_owner_idx) == NUM_MASTERS - 1) ? '0 : w_owner_idx + 1'b1;
    assign w_term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign w_stall   = (r_state == ST_BUSY) && w_own_cyc && w_own_stb && !w_term;
    assign w_expire  = (TIMEOUT != 0) && w_stall && (r_wd == WD_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_wd_nxt    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_pick_gnt;
                end
            end
            ST_BUSY: begin
                if (!w_own_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_inc;
                end else if ((TIMEOUT != 0) && w_stall && !w_expire) begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        wbs_adr_o = w_own_adr;
        wbs_dat_o = w_own_dat;
        wbs_sel_o = w_own_sel;
        wbs_we_o  = w_own_we;
        wbs_cti_o = w_own_cti;
        wbs_bte_o = w_own_bte;
        wbs_cyc_o = w_own_cyc;
        wbs_stb_o = w_own_cyc && w_own_stb && !w_expire;
        wbm_dat_o = wbs_dat_i;
        wbm_ack_o = r_grant & {NUM_MASTERS{wbs_ack_i}};
        wbm_err_o = r_grant & {NUM_MASTERS{wbs_err_i | w_expire}};
        wbm_rty_o = r_grant & {NUM_MASTERS{wbs_rty_i}};
        grant_o   = r_grant;
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: table of per-cycle vectors plus hand-written
// burst, watchdog and mid-cycle reset sequences.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*AW-1:0]   m_adr;
    logic [N*DW-1:0]   m_dat;
    logic [N*SW-1:0]   m_sel;
    logic [N-1:0]      m_we, m_cyc, m_stb;
    logic [N*3-1:0]    m_cti;
    logic [N*2-1:0]    m_bte;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      ack_o, err_o, rty_o, gnt;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o, s_dat_i;
    logic [SW-1:0]     s_sel;
    logic              s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] adr_tab [N];
    logic [DW-1:0] dat_tab [N];
    logic [SW-1:0] sel_tab [N];
    logic          we_tab  [N];

    wb_rr_arbiter #(.NUM_MASTERS(N), .aw(AW), .dw(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbm_adr_i (m_adr),
        .wbm_dat_i (m_dat),
        .wbm_sel_i (m_sel),
        .wbm_we_i  (m_we),
        .wbm_cyc_i (m_cyc),
        .wbm_stb_i (m_stb),
        .wbm_cti_i (m_cti),
        .wbm_bte_i (m_bte),
        .wbm_dat_o (m_dat_o),
        .wbm_ack_o (ack_o),
        .wbm_err_o (err_o),
        .wbm_rty_o (rty_o),
        .wbs_adr_o (s_adr),
        .wbs_dat_o (s_dat_o),
        .wbs_sel_o (s_sel),
        .wbs_we_o  (s_we),
        .wbs_cyc_o (s_cyc),
        .wbs_stb_o (s_stb),
        .wbs_cti_o (s_cti),
        .wbs_bte_o (s_bte),
        .wbs_dat_i (s_dat_i),
        .wbs_ack_i (s_ack),
        .wbs_err_i (s_err),
        .wbs_rty_i (s_rty),
        .grant_o   (gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         pre_rst;
        logic [3:0] cyc, stb;
        logic       ack, err, rty;
        logic [3:0] e_gnt;
        logic       e_cyc, e_stb;
        logic [3:0] e_ack, e_err, e_rty;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [3:0] c, logic [3:0] s, logic a, logic e, logic y,
                                logic [3:0] g, logic ec, logic es,
                                logic [3:0] ea, logic [3:0] ee, logic [3:0] ey);
        vec_t v;
        v.pre_rst = r; v.cyc = c; v.stb = s; v.ack = a; v.err = e; v.rty = y;
        v.e_gnt = g; v.e_cyc = ec; v.e_stb = es; v.e_ack = ea; v.e_err = ee; v.e_rty = ey;
        return v;
    endfunction

    function automatic int owner_of(input logic [N-1:0] g);
        int r;
        r = -1;
        for (int m = 0; m < N; m++) if (g[m]) r = m;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_i = 32'h0BAD_F00D;
        for (int m = 0; m < N; m++) begin
            m_adr[m*AW +: AW] = adr_tab[m];
            m_dat[m*DW +: DW] = dat_tab[m];
            m_sel[m*SW +: SW] = sel_tab[m];
            m_we[m]           = we_tab[m];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #2;
        chk("rst_grant", gnt, 0);
        chk("rst_cyc", s_cyc, 0);
        chk("rst_stb", s_stb, 0);
        chk("rst_ack_err_rty", {ack_o, err_o, rty_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        int o;
        if (v.pre_rst) do_reset();
        m_cyc = v.cyc; m_stb = v.stb;
        s_ack = v.ack; s_err = v.err; s_rty = v.rty;
        #2;
        o = owner_of(v.e_gnt);
        chk($sformatf("v%0d_grant", idx), gnt, v.e_gnt);
        chk($sformatf("v%0d_cyc", idx), s_cyc, v.e_cyc);
        chk($sformatf("v%0d_stb", idx), s_stb, v.e_stb);
        chk($sformatf("v%0d_ack", idx), ack_o, v.e_ack);
        chk($sformatf("v%0d_err", idx), err_o, v.e_err);
        chk($sformatf("v%0d_rty", idx), rty_o, v.e_rty);
        chk($sformatf("v%0d_adr", idx), s_adr, (o < 0) ? 32'h0 : adr_tab[o]);
        chk($sformatf("v%0d_dat", idx), s_dat_o, (o < 0) ? 32'h0 : dat_tab[o]);
        chk($sformatf("v%0d_sel", idx), s_sel, (o < 0) ? 4'h0 : sel_tab[o]);
        chk($sformatf("v%0d_we", idx), s_we, (o < 0) ? 1'b0 : we_tab[o]);
        step();
    endtask

    initial begin
        adr_tab[0] = 32'h0000_0100; dat_tab[0] = 32'hDEAD_BEEF; sel_tab[0] = 4'hF; we_tab[0] = 1'b1;
        adr_tab[1] = 32'h0000_0200; dat_tab[1] = 32'h1111_2222; sel_tab[1] = 4'h3; we_tab[1] = 1'b0;
        adr_tab[2] = 32'h0000_0300; dat_tab[2] = 32'h3333_4444; sel_tab[2] = 4'hC; we_tab[2] = 1'b1;
        adr_tab[3] = 32'h0000_0400; dat_tab[3] = 32'h5555_6666; sel_tab[3] = 4'h1; we_tab[3] = 1'b0;
        clear_inputs();

        // masters 0 and 2 together: 0 first, one idle cycle, then 2
        vecs.push_back(mk(1, 4'b0101, 4'b0101, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 4'b0101, 1, 0, 0, 4'b0001, 1, 1, 4'b0001, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 0, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 0, 0, 4'b0100, 1, 1, 4'b0100, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        // all four requesting: order 0,1,2,3,0 with ack/err/rty pass-through
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 0, 4'b0001, 1, 1, 4'b0001, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1110, 4'b1110, 0, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 0, 4'b0010, 1, 1, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1101, 4'b1101, 0, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 0, 4'b0100, 1, 1, 4'b0000, 4'b0100, 4'b0000));
        vecs.push_back(mk(0, 4'b1011, 4'b1011, 0, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 1, 4'b1000, 1, 1, 4'b0000, 4'b0000, 4'b1000));
        vecs.push_back(mk(0, 4'b0111, 4'b0111, 0, 0, 0, 4'b1000, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 0, 4'b0001, 1, 1, 4'b0001, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000));

        for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

        // 8-beat incrementing burst from master 1 while master 3 waits
        do_reset();
        m_cyc = 4'b1010; m_stb = 4'b1010;
        #2 chk("burst_idle_grant", gnt, 4'b0000);
        step();
        for (int b = 0; b < 8; b++) begin
            m_adr[1*AW +: AW] = 32'h0000_2000 + 32'(b * 4);
            m_cti[1*3 +: 3]   = (b == 7) ? 3'b111 : 3'b010;
            m_bte[1*2 +: 2]   = 2'b00;
            s_ack   = 1'b1;
            s_dat_i = 32'h0000_5500 + 32'(b);
            #2;
            chk($sformatf("burst%0d_grant", b), gnt, 4'b0010);
            chk($sformatf("burst%0d_ack", b), ack_o, 4'b0010);
            chk($sformatf("burst%0d_adr", b), s_adr, 32'h0000_2000 + 32'(b * 4));
            chk($sformatf("burst%0d_cti", b), s_cti, (b == 7) ? 3'b111 : 3'b010);
            chk($sformatf("burst%0d_rdat", b), m_dat_o, 32'h0000_5500 + 32'(b));
            step();
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti = '0; s_ack = 1'b0;
        #2;
        chk("burst_drop_grant", gnt, 4'b0010);
        chk("burst_drop_cyc", s_cyc, 1'b0);
        step();
        #2 chk("burst_gap_grant", gnt, 4'b0000);
        step();
        #2;
        chk("burst_next_grant", gnt, 4'b1000);
        chk("burst_next_adr", s_adr, adr_tab[3]);

        // watchdog: err pulse on the 16th stalled cycle with stb forced low
        do_reset();
        m_cyc = 4'b0011; m_stb = 4'b0011;
        step();
        for (int k = 1; k <= TO + 1; k++) begin
            #2;
            chk($sformatf("wd%0d_err", k), err_o, (k == TO) ? 4'b0001 : 4'b0000);
            chk($sformatf("wd%0d_stb", k), s_stb, (k == TO) ? 1'b0 : 1'b1);
            chk($sformatf("wd%0d_grant", k), gnt, 4'b0001);
            step();
        end
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #2 chk("wd_drop_grant", gnt, 4'b0001);
        step();
        #2 chk("wd_gap_grant", gnt, 4'b0000);
        step();
        #2 chk("wd_next_grant", gnt, 4'b0010);

        // slave ack on the very cycle the watchdog would expire
        do_reset();
        m_cyc = 4'b0001; m_stb = 4'b0001;
        step();
        for (int k = 1; k < TO; k++) begin
            #2 chk($sformatf("race%0d_err", k), err_o, 4'b0000);
            step();
        end
        s_ack = 1'b1;
        #2;
        chk("race_ack", ack_o, 4'b0001);
        chk("race_err", err_o, 4'b0000);
        chk("race_stb", s_stb, 1'b1);
        step();
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        step();

        // reset in the middle of master 2's burst, with pointer previously at 2
        do_reset();
        m_cyc = 4'b0010; m_stb = 4'b0010;
        step();
        s_ack = 1'b1;
        #2 chk("mr_m1_grant", gnt, 4'b0010);
        step();
        m_cyc = 4'b0100; m_stb = 4'b0100; s_ack = 1'b0;
        step();
        m_cti[2*3 +: 3] = 3'b010;
        step();
        s_ack = 1'b1;
        #2 chk("mr_m2_grant", gnt, 4'b0100);
        step();
        m_cyc = 4'b0101; m_stb = 4'b0101;
        #1 chk("mr_cyc_before", s_cyc, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_cyc_async", s_cyc, 1'b0);
        chk("mr_grant_async", gnt, 4'b0000);
        chk("mr_ack_async", ack_o, 4'b0000);
        #3 rst_n = 1'b1;
        s_ack = 1'b0;
        step();
        #2 chk("mr_after_grant", gnt, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
